lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit sitting directly upstream of dmem; the only master of dmem's port.
- Converts core byte-addressed RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into dmem's word-indexed accesses.
- Sub-word stores use read-modify-write, because dmem has no byte enables.
- Accesses that cross a word boundary are split into two word accesses.
- Loads are aligned and sign/zero-extended before return.

Parameters:
- XLEN, `XLEN (32): data/address width.
- MEM_WORDS, 2048: dmem depth in words; word index >= MEM_WORDS is an access fault.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (size/signedness)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, LSB-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  XLEN  load result (0 for stores and errors)
- resp_err  out  1  fault/illegal flag, valid with resp_valid
- mem_addr  out  XLEN  word index to dmem
- mem_write_data  out  XLEN  merged write word
- mem_read_data  in  XLEN  dmem combinational read data, valid when write_en=0
- write_en  out  1  dmem write strobe
- mem_en  out  1  high in every RD/WR state

Behaviour:
- Reset: state=IDLE. req_ready=1. resp_valid, resp_err, resp_rdata, mem_addr, mem_write_data, write_en and mem_en are all 0.
- Accept cycle T: latch we, funct3, addr, wdata.
- Derived values: off=addr[1:0]; size sz=1/2/4 from funct3[1:0]; w0=addr>>2; w1=(w0+1) mod 2^(XLEN-2); cross = off+sz>4.
- Legal funct3:
  - loads: 000, 001, 010, 100, 101
  - stores: 000, 001, 010
  - anything else is illegal.
- Error path: if funct3 is illegal, or w0>=MEM_WORDS, or (cross and w1>=MEM_WORDS), go IDLE->DONE with resp_err=1. No memory access occurs and mem_en stays 0.
- States: IDLE, RD0, WR0, RD1, WR1, DONE. Each non-IDLE state lasts exactly 1 cycle.
- RDn: mem_addr=wn, write_en=0; capture mem_read_data into buf_n.
- WRn: mem_addr=wn, write_en=1, mem_write_data=merged buf_n. The write lands at the end of the cycle.
- Sequences and resp_valid timing:
  - aligned/non-crossing load: RD0, DONE; resp_valid at T+2.
  - crossing load: RD0, RD1, DONE; T+3.
  - SW with off=0: WR0 (buf ignored), DONE; T+2.
  - non-crossing sub-word store: RD0, WR0, DONE; T+3.
  - crossing store: RD0, WR0, RD1, WR1, DONE; T+5.
- Byte order is little-endian.
- Load data: take ({buf1,buf0} >> 8*off) low sz bytes. Sign-extend for funct3 000/001; zero-extend for 100/101.
- Store merge:
  - w0: bytes off..min(3, off+sz-1) are replaced by wdata bytes 0..; other bytes are kept.
  - w1: bytes 0..(off+sz-5) are replaced by the remaining wdata bytes.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_err hold until the next DONE.
- Requests are not accepted outside IDLE. req_valid in the DONE cycle is accepted only on the following IDLE cycle, so there is no back-to-back acceptance.
- rst mid-operation: return to IDLE immediately and drive all outputs to reset values; no response is issued.
  - Any WR0 already completed stays in memory; there is no rollback.
  - rst wins over a simultaneous req_valid.
- Whenever write_en=0, mem_write_data=0.

Test Plan:
- Preload datamem[4]=0xDEADBEEF; LW addr 0x10 at T -> resp_valid at T+2, resp_rdata=0xDEADBEEF, resp_err=0, write_en never 1.
- LB addr 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD.
- SB wdata 0x5A addr 0x11 -> sequence RD0, WR0, DONE, resp at T+3, datamem[4]=0xDEAD5AEF.
- Preload datamem[5]=0x12345678, datamem[4]=0xDEADBEEF:
  - LW 0x12 -> resp at T+3, rdata=0x5678DEAD.
  - SW 0xAABBCCDD at 0x13 -> resp at T+5, datamem[4]=0xDDADBEEF, datamem[5]=0x12AABBCC.
- LW addr 0x2000 (word 2048) -> resp at T+1 with resp_err=1, mem_en=0 throughout. Load funct3=011 -> same response. SW at 0x1FFD (crosses to word 2048) -> resp_err=1, datamem[2047] unchanged.
- Assert rst during WR1 of a crossing SW -> next cycle req_ready=1, resp_valid=0, datamem[5] unchanged. Then issue a new LW -> normal response.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: turns RV32I byte-addressed loads/stores into word accesses on a byte-enable-less dmem.
// Response 1 (fault) to 5 (crossing store) cycles after accept; one request in flight, req_ready only in IDLE.
module lsu_ctrl #(
  parameter int XLEN      = 32,
  parameter int MEM_WORDS = 2048
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_write_data,
  input  logic [XLEN-1:0] mem_read_data,
  output logic            write_en,
  output logic            mem_en
);
  localparam int AW = XLEN - 2;

  typedef enum logic [2:0] {IDLE, RD0, WR0, RD1, WR1, DONE} state_t;

  state_t          state_q, state_d;
  logic            we_q, we_d, cross_q, cross_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [AW-1:0]   w0_q, w0_d, w1_q, w1_d;
  logic [XLEN-1:0] wdata_q, wdata_d, buf0_q, buf0_d;
  logic            req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d, write_en_q, write_en_d, mem_en_q, mem_en_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d, mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_write_data_q, mem_write_data_d;

  logic [AW-1:0]     req_w0, req_w1;
  logic              req_cross, req_fault, req_full_word;
  logic [2*XLEN-1:0] merged;
  logic [XLEN-1:0]   load_val;

  function automatic logic [3:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {3'b000, 3'b001, 3'b010};
    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  // Two-word view {w1, w0}: the low half is the w0 merge, the high half the w1 merge.
  function automatic logic [2*XLEN-1:0] merge(input logic [2*XLEN-1:0] old, input logic [XLEN-1:0] wd,
                                              input logic [2:0] f3, input logic [1:0] off);
    logic [2*XLEN-1:0] m;
    case (f3[1:0])
      2'b00:   m = {{(2*XLEN-8){1'b0}}, 8'hFF};
      2'b01:   m = {{(2*XLEN-16){1'b0}}, 16'hFFFF};
      default: m = {{XLEN{1'b0}}, {XLEN{1'b1}}};
    endcase
    m = m << {off, 3'b000};
    return (old & ~m) | (({{XLEN{1'b0}}, wd} << {off, 3'b000}) & m);
  endfunction

  function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] src, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [XLEN-1:0] w;
    w = src[{1'b0, off, 3'b000} +: XLEN];
    case (f3)
      3'b000:  return {{(XLEN-8){w[7]}}, w[7:0]};
      3'b001:  return {{(XLEN-16){w[15]}}, w[15:0]};
      3'b100:  return {{(XLEN-8){1'b0}}, w[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  always_comb begin
    req_w0        = req_addr[XLEN-1:2];
    req_w1        = req_w0 + AW'(1);
    req_cross     = ({2'b00, req_addr[1:0]} + size_of(req_funct3)) > 4'd4;
    req_fault     = !legal(req_we, req_funct3)
                    || (XLEN'(req_w0) >= XLEN'(MEM_WORDS))
                    || (req_cross && (XLEN'(req_w1) >= XLEN'(MEM_WORDS)));
    req_full_word = (req_funct3[1:0] == 2'b10) && (req_addr[1:0] == 2'b00);
  end

  always_comb begin
    state_d          = state_q;
    we_d             = we_q;
    f3_d             = f3_q;
    off_d            = off_q;
    cross_d          = cross_q;
    w0_d             = w0_q;
    w1_d             = w1_q;
    wdata_d          = wdata_q;
    buf0_d           = buf0_q;
    resp_valid_d     = 1'b0;
    resp_rdata_d     = resp_rdata_q;
    resp_err_d       = resp_err_q;
    mem_en_d         = 1'b0;
    write_en_d       = 1'b0;
    mem_addr_d       = '0;
    mem_write_data_d = '0;
    merged           = merge({mem_read_data, mem_read_data}, wdata_q, f3_q, off_q);
    load_val         = extract({mem_read_data, (state_q == RD1) ? buf0_q : mem_read_data}, f3_q, off_q);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          off_d   = req_addr[1:0];
          cross_d = req_cross;
          w0_d    = req_w0;
          w1_d    = req_w1;
          wdata_d = req_wdata;
          if (req_fault) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_we && req_full_word) begin
            state_d          = WR0;
            mem_en_d         = 1'b1;
            write_en_d       = 1'b1;
            mem_addr_d       = XLEN'(req_w0);
            mem_write_data_d = req_wdata;
          end else begin
            state_d    = RD0;
            mem_en_d   = 1'b1;
            mem_addr_d = XLEN'(req_w0);
          end
        end
      end
      RD0: begin
        buf0_d = mem_read_data;
        if (we_q) begin
          state_d          = WR0;
          mem_en_d         = 1'b1;
          write_en_d       = 1'b1;
          mem_addr_d       = XLEN'(w0_q);
          mem_write_data_d = merged[XLEN-1:0];
        end else if (cross_q) begin
          state_d    = RD1;
          mem_en_d   = 1'b1;
          mem_addr_d = XLEN'(w1_q);
        end else begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_val;
        end
      end
      WR0: begin
        if (cross_q) begin
          state_d    = RD1;
          mem_en_d   = 1'b1;
          mem_addr_d = XLEN'(w1_q);
        end else begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end
      end
      RD1: begin
        if (we_q) begin
          state_d          = WR1;
          mem_en_d         = 1'b1;
          write_en_d       = 1'b1;
          mem_addr_d       = XLEN'(w1_q);
          mem_write_data_d = merged[2*XLEN-1:XLEN];
        end else begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_val;
        end
      end
      WR1: begin
        state_d      = DONE;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      we_q             <= 1'b0;
      f3_q             <= '0;
      off_q            <= '0;
      cross_q          <= 1'b0;
      w0_q             <= '0;
      w1_q             <= '0;
      wdata_q          <= '0;
      buf0_q           <= '0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= '0;
      resp_err_q       <= 1'b0;
      mem_en_q         <= 1'b0;
      write_en_q       <= 1'b0;
      mem_addr_q       <= '0;
      mem_write_data_q <= '0;
    end else begin
      state_q          <= state_d;
      we_q             <= we_d;
      f3_q             <= f3_d;
      off_q            <= off_d;
      cross_q          <= cross_d;
      w0_q             <= w0_d;
      w1_q             <= w1_d;
      wdata_q          <= wdata_d;
      buf0_q           <= buf0_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_rdata_q     <= resp_rdata_d;
      resp_err_q       <= resp_err_d;
      mem_en_q         <= mem_en_d;
      write_en_q       <= write_en_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  // rst forces reset values in the same cycle, so a pending WR1 strobe never reaches dmem.
  assign req_ready      = req_ready_q | rst;
  assign resp_valid     = resp_valid_q & ~rst;
  assign resp_err       = resp_err_q & ~rst;
  assign resp_rdata     = rst ? '0 : resp_rdata_q;
  assign mem_en         = mem_en_q & ~rst;
  assign write_en       = write_en_q & ~rst;
  assign mem_addr       = rst ? '0 : mem_addr_q;
  assign mem_write_data = rst ? '0 : mem_write_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural dmem; expected responses are queued at issue and
// compared (data, error, latency) when resp_valid fires.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        write_en, mem_en;

  logic [31:0] dmem [0:2047];
  logic        pre_we;
  logic [10:0] pre_addr;
  logic [31:0] pre_dat;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .write_en       (write_en),
    .mem_en         (mem_en)
  );

  assign mem_read_data = (mem_addr < 32'd2048) ? dmem[mem_addr[10:0]] : 32'h0;

  always @(posedge clk) begin
    if (write_en && mem_addr < 32'd2048) dmem[mem_addr[10:0]] <= mem_write_data;
    else if (pre_we) dmem[pre_addr] <= pre_dat;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [10:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_dat = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one request and waits (bounded) for its response; latency counts edges from the accept edge.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee, input int el);
    exp_t e;
    int   lat;
    logic got, saw_we, saw_en;
    exp_q.push_back('{rdata: er, err: ee, lat: el});
    @(negedge clk);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    lat = 0; got = 1'b0; saw_we = 1'b0; saw_en = 1'b0;
    while (!got && lat < 12) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      saw_we |= write_en;
      saw_en |= mem_en;
      if (resp_valid) got = 1'b1;
      else @(posedge clk);
    end
    e = exp_q.pop_front();
    check({tag, " resp seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, " rdata"}, resp_rdata, e.rdata);
      check({tag, " err"}, 32'(resp_err), 32'(e.err));
      check({tag, " latency"}, 32'(lat), 32'(e.lat));
    end
    if (!we) check({tag, " no write_en"}, 32'(saw_we), 32'd0);
    if (ee) check({tag, " no mem_en"}, 32'(saw_en), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_write_data", mem_write_data, 32'd0);
    check("rst write_en", 32'(write_en), 32'd0);
    check("rst mem_en", 32'(mem_en), 32'd0);

    preload(11'd4, 32'hDEADBEEF);
    preload(11'd2047, 32'hCAFEF00D);

    do_req("lw 0x10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    do_req("lb 0x13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
    @(negedge clk);
    check("hold resp_rdata", resp_rdata, 32'hFFFFFFDE);
    check("hold resp_valid low", 32'(resp_valid), 32'd0);
    do_req("lbu 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2);
    do_req("lh 0x12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2);
    do_req("lhu 0x12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 2);

    do_req("sb 0x11", 1'b1, 3'b000, 32'h11, 32'h0000005A, 32'h0, 1'b0, 3);
    check("sb mem4", dmem[4], 32'hDEAD5AEF);

    preload(11'd4, 32'hDEADBEEF);
    preload(11'd5, 32'h12345678);
    do_req("lw cross 0x12", 1'b0, 3'b010, 32'h12, 32'h0, 32'h5678DEAD, 1'b0, 3);
    do_req("lh cross 0x13", 1'b0, 3'b001, 32'h13, 32'h0, 32'h000078DE, 1'b0, 3);

    do_req("sw cross 0x13", 1'b1, 3'b010, 32'h13, 32'hAABBCCDD, 32'h0, 1'b0, 5);
    check("sw cross mem4", dmem[4], 32'hDDADBEEF);
    check("sw cross mem5", dmem[5], 32'h12AABBCC);

    do_req("sh 0x16", 1'b1, 3'b001, 32'h16, 32'h0000BEEF, 32'h0, 1'b0, 3);
    do_req("lw 0x14", 1'b0, 3'b010, 32'h14, 32'h0, 32'hBEEFBBCC, 1'b0, 2);
    do_req("sw 0x18", 1'b1, 3'b010, 32'h18, 32'h11223344, 32'h0, 1'b0, 2);
    check("sw aligned mem6", dmem[6], 32'h11223344);
    do_req("lw 0x18", 1'b0, 3'b010, 32'h18, 32'h0, 32'h11223344, 1'b0, 2);

    do_req("lw oob", 1'b0, 3'b010, 32'h2000, 32'h0, 32'h0, 1'b1, 1);
    do_req("ld f3=011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    do_req("sw cross oob", 1'b1, 3'b010, 32'h1FFD, 32'h55667788, 32'h0, 1'b1, 1);
    check("oob mem2047", dmem[2047], 32'hCAFEF00D);
    do_req("st f3=100", 1'b1, 3'b100, 32'h10, 32'h99999999, 32'h0, 1'b1, 1);
    check("illegal st mem4", dmem[4], 32'hDDADBEEF);

    // Reset landing in WR1 of a crossing store: WR0 sticks, WR1 never reaches dmem.
    preload(11'd4, 32'hDEADBEEF);
    preload(11'd5, 32'h12345678);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h13; req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("wr1 write_en", 32'(write_en), 32'd1);
    check("wr1 mem_addr", mem_addr, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post rst req_ready", 32'(req_ready), 32'd1);
    check("post rst resp_valid", 32'(resp_valid), 32'd0);
    check("post rst resp_rdata", resp_rdata, 32'd0);
    check("post rst mem5", dmem[5], 32'h12345678);
    check("post rst mem4 kept", dmem[4], 32'hDDADBEEF);
    @(negedge clk);
    check("post rst no resp", 32'(resp_valid), 32'd0);
    do_req("lw after rst", 1'b0, 3'b010, 32'h14, 32'h0, 32'h12345678, 1'b0, 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
